// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lets N_REQ requesters share one I2C byte-write/random-read master.
// Requests are latched on grant; the master is watched for done/error edges or a run timeout.
module i2c_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned GAP_CYCLES     = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [8*N_REQ-1:0] req_dev_addr,
  input  logic [8*N_REQ-1:0] req_word_addr,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic               rsp_error,
  output logic [7:0]         rsp_rdata,
  output logic [7:0]         i2c_device_address,
  output logic [7:0]         i2c_word_address,
  output logic [7:0]         i2c_data_write,
  output logic [7:0]         i2c_in_signals,
  input  logic [7:0]         i2c_out_signals,
  input  logic [7:0]         i2c_data_read,
  output logic               busy,
  output logic [2:0]         grant_id
);

  localparam int unsigned CntMax = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);
  localparam logic [2:0]      LastId      = 3'(N_REQ - 1);
  localparam logic [N_REQ-1:0] OneHot0    = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StGrant, StRun, StResp, StGap} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [1:0]      out_prev;
  logic            rw_q;

  logic            any_req;
  logic [2:0]      winner;
  int unsigned     rr_idx;
  logic [N_REQ-1:0] valid_sh;
  logic [N_REQ-1:0] rw_sh;
  logic            sel_rw;
  logic [7:0]      sel_dev;
  logic [7:0]      sel_word;
  logic [7:0]      sel_wdata;
  logic            done_rise;
  logic            err_rise;
  logic            unused_out;

  assign busy       = (state != StIdle);
  assign done_rise  = i2c_out_signals[0] & ~out_prev[0];
  assign err_rise   = i2c_out_signals[1] & ~out_prev[1];
  assign unused_out = ^i2c_out_signals[7:2];

  // Scan from furthest to nearest so the nearest valid requester after grant_id wins.
  always_comb begin
    any_req  = |req_valid;
    winner   = grant_id;
    rr_idx   = 0;
    valid_sh = '0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      rr_idx   = (32'(grant_id) + k) % N_REQ;
      valid_sh = req_valid >> rr_idx;
      if (valid_sh[0]) winner = 3'(rr_idx);
    end
    rw_sh     = req_rw >> winner;
    sel_rw    = rw_sh[0];
    sel_dev   = 8'(req_dev_addr >> (32'(winner) * 8));
    sel_word  = 8'(req_word_addr >> (32'(winner) * 8));
    sel_wdata = 8'(req_wdata >> (32'(winner) * 8));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= StIdle;
      cnt                <= '0;
      out_prev           <= '0;
      rw_q               <= 1'b0;
      grant_id           <= LastId;
      req_ready          <= '0;
      rsp_valid          <= '0;
      rsp_error          <= 1'b0;
      rsp_rdata          <= '0;
      i2c_device_address <= '0;
      i2c_word_address   <= '0;
      i2c_data_write     <= '0;
      i2c_in_signals     <= '0;
    end else begin
      out_prev  <= i2c_out_signals[1:0];
      req_ready <= '0;
      rsp_valid <= '0;
      unique case (state)
        StIdle: begin
          if (any_req) begin
            state              <= StGrant;
            grant_id           <= winner;
            rw_q               <= sel_rw;
            i2c_device_address <= sel_dev;
            i2c_word_address   <= sel_word;
            i2c_data_write     <= sel_wdata;
            req_ready          <= OneHot0 << winner;
          end
        end
        StGrant: begin
          state          <= StRun;
          cnt            <= '0;
          i2c_in_signals <= {6'b0, rw_q, 1'b1};
        end
        StRun: begin
          if (err_rise || done_rise) begin
            state          <= StResp;
            rsp_valid      <= OneHot0 << grant_id;
            rsp_error      <= err_rise;
            rsp_rdata      <= (rw_q && !err_rise) ? i2c_data_read : 8'h00;
            i2c_in_signals <= '0;
          end else if (cnt == TimeoutLast) begin
            // Abort: one-cycle reset pulse to the master overlaps the response cycle.
            state          <= StResp;
            rsp_valid      <= OneHot0 << grant_id;
            rsp_error      <= 1'b1;
            rsp_rdata      <= 8'h00;
            i2c_in_signals <= 8'h04;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StResp: begin
          state          <= StGap;
          cnt            <= '0;
          i2c_in_signals <= '0;
        end
        StGap: begin
          if (cnt == GapLast) state <= StIdle;
          else cnt <= cnt + 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter: stimulus queues expected grants/responses, monitors pop them.
module tb_i2c_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned TO  = 100;
  localparam int unsigned GAP = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid, req_rw, req_ready, rsp_valid;
  logic [8*N-1:0] req_dev_addr, req_word_addr, req_wdata;
  logic           rsp_error, busy;
  logic [7:0]     rsp_rdata, i2c_device_address, i2c_word_address, i2c_data_write;
  logic [7:0]     i2c_in_signals, i2c_out_signals, i2c_data_read;
  logic [2:0]     grant_id;

  i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_rw(req_rw),
    .req_dev_addr(req_dev_addr), .req_word_addr(req_word_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_error(rsp_error),
    .rsp_rdata(rsp_rdata), .i2c_device_address(i2c_device_address),
    .i2c_word_address(i2c_word_address), .i2c_data_write(i2c_data_write),
    .i2c_in_signals(i2c_in_signals), .i2c_out_signals(i2c_out_signals),
    .i2c_data_read(i2c_data_read), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {int id; logic [7:0] dev; logic [7:0] word; logic [7:0] wd;} grant_t;
  typedef struct {int id; logic err; logic [7:0] rd;} rsp_t;

  grant_t gq[$];
  rsp_t   rq[$];
  int     checks = 0;
  int     errors = 0;

  // Master model controls
  logic       silent = 1'b0;
  logic       nack = 1'b0;
  int         lat = 3;
  logic [7:0] rd_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_grant(input int id, input logic [7:0] d, input logic [7:0] w,
                           input logic [7:0] x);
    grant_t g;
    g.id = id; g.dev = d; g.word = w; g.wd = x;
    gq.push_back(g);
  endtask

  task automatic exp_rsp(input int id, input logic err, input logic [7:0] rd);
    rsp_t r;
    r.id = id; r.err = err; r.rd = rd;
    rq.push_back(r);
  endtask

  task automatic set_req(input int i, input logic rw, input logic [7:0] d,
                         input logic [7:0] w, input logic [7:0] x);
    req_rw[i]             = rw;
    req_dev_addr[8*i +: 8]  = d;
    req_word_addr[8*i +: 8] = w;
    req_wdata[8*i +: 8]     = x;
    req_valid[i]          = 1'b1;
  endtask

  task automatic wait_ready(input int i);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("ready_wait_expired", 32'(i), 32'hFFFF);
  endtask

  task automatic wait_start();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (i2c_in_signals[0]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("start_wait_expired", 0, 1);
  endtask

  task automatic wait_idle();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!busy) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("idle_wait_expired", 0, 1);
  endtask

  // I2C master model: raises done (and error when nack) lat cycles into a start, drops with start.
  initial begin : master
    int run_cnt;
    run_cnt         = 0;
    i2c_out_signals = 8'h00;
    i2c_data_read   = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (i2c_in_signals[0] && !silent) begin
        if (run_cnt == lat) begin
          i2c_out_signals = {6'b0, nack, 1'b1};
          i2c_data_read   = rd_val;
        end
        run_cnt++;
      end else begin
        run_cnt         = 0;
        i2c_out_signals = 8'h00;
      end
    end
  end

  initial begin : ready_mon
    grant_t g;
    forever begin
      @(negedge clk);
      if (!reset && req_ready != '0) begin
        if (gq.size() == 0) begin
          chk("unexpected_ready", 32'(req_ready), 0);
        end else begin
          g = gq.pop_front();
          chk("ready_onehot", 32'(req_ready), 32'(1) << g.id);
          chk("grant_id", 32'(grant_id), 32'(g.id));
          chk("dev_addr", 32'(i2c_device_address), 32'(g.dev));
          chk("word_addr", 32'(i2c_word_address), 32'(g.word));
          chk("wdata", 32'(i2c_data_write), 32'(g.wd));
        end
      end
    end
  end

  initial begin : rsp_mon
    rsp_t r;
    forever begin
      @(negedge clk);
      if (!reset && rsp_valid != '0) begin
        if (rq.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 0);
        end else begin
          r = rq.pop_front();
          chk("rsp_onehot", 32'(rsp_valid), 32'(1) << r.id);
          chk("rsp_error", 32'(rsp_error), 32'(r.err));
          chk("rsp_rdata", 32'(rsp_rdata), 32'(r.rd));
        end
      end
    end
  end

  initial begin : gap_mon
    int low;
    bit seen;
    low  = 0;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        seen = 1'b0;
        low  = 0;
      end else if (i2c_in_signals[0]) begin
        if (seen && low > 0) chk("start_low_gap", 32'(low >= int'(GAP)), 1);
        seen = 1'b1;
        low  = 0;
      end else begin
        low++;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int order [5];
    order = '{0, 1, 2, 3, 0};
    reset         = 1'b1;
    req_valid     = '0;
    req_rw        = '0;
    req_dev_addr  = '0;
    req_word_addr = '0;
    req_wdata     = '0;
    repeat (3) tick();
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_error", 32'(rsp_error), 0);
    chk("rst_rdata", 32'(rsp_rdata), 0);
    chk("rst_in_signals", 32'(i2c_in_signals), 0);
    chk("rst_dev", 32'(i2c_device_address), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant_id", 32'(grant_id), 3);
    reset = 1'b0;
    tick();

    // Single write from requester 0
    exp_grant(0, 8'hA0, 8'h55, 8'h22);
    exp_rsp(0, 1'b0, 8'h00);
    set_req(0, 1'b0, 8'hA0, 8'h55, 8'h22);
    wait_ready(0);
    tick();
    req_valid[0] = 1'b0;
    wait_start();
    chk("write_in_signals", 32'(i2c_in_signals), 32'h01);
    wait_idle();

    // Random read from requester 2; inputs change after accept, requester 1 withdraws
    lat    = 3;
    rd_val = 8'h5A;
    exp_grant(2, 8'hA1, 8'h10, 8'h99);
    exp_rsp(2, 1'b0, 8'h5A);
    set_req(2, 1'b1, 8'hA1, 8'h10, 8'h99);
    wait_ready(2);
    tick();
    req_valid[2]         = 1'b0;
    req_dev_addr[23:16] = 8'hFF;
    req_valid[1]         = 1'b1;
    wait_start();
    chk("read_in_signals", 32'(i2c_in_signals), 32'h03);
    chk("latched_dev", 32'(i2c_device_address), 32'hA1);
    tick();
    req_valid[1] = 1'b0;
    wait_idle();
    chk("hold_rdata", 32'(rsp_rdata), 32'h5A);
    chk("hold_error", 32'(rsp_error), 0);

    // NACK: error and done rise together on a read
    nack   = 1'b1;
    rd_val = 8'h77;
    exp_grant(1, 8'hA2, 8'h20, 8'h00);
    exp_rsp(1, 1'b1, 8'h00);
    set_req(1, 1'b1, 8'hA2, 8'h20, 8'h00);
    wait_ready(1);
    tick();
    req_valid[1] = 1'b0;
    wait_idle();
    nack = 1'b0;

    // Timeout with a silent master
    silent = 1'b1;
    exp_grant(3, 8'hA3, 8'h30, 8'h44);
    exp_rsp(3, 1'b1, 8'h00);
    set_req(3, 1'b0, 8'hA3, 8'h30, 8'h44);
    wait_ready(3);
    tick();
    req_valid[3] = 1'b0;
    n = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (i2c_in_signals == 8'h01) n++;
      else break;
    end
    chk("timeout_run_len", 32'(n), 32'(TO));
    chk("timeout_pulse", 32'(i2c_in_signals), 32'h04);
    @(negedge clk);
    chk("timeout_after", 32'(i2c_in_signals), 32'h00);
    wait_idle();

    // Reset in the middle of a run
    exp_grant(1, 8'hB1, 8'h40, 8'h55);
    set_req(1, 1'b0, 8'hB1, 8'h40, 8'h55);
    wait_ready(1);
    tick();
    req_valid[1] = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("midrun_in_signals", 32'(i2c_in_signals), 0);
    chk("midrun_busy", 32'(busy), 0);
    chk("midrun_rsp_valid", 32'(rsp_valid), 0);
    repeat (2) tick();
    reset  = 1'b0;
    silent = 1'b0;
    tick();
    chk("post_rst_grant_id", 32'(grant_id), 3);

    // Contention: all four held valid, expect 0,1,2,3,0
    lat = 2;
    for (int g = 0; g < 5; g++) begin
      exp_grant(order[g], 8'h10 + 8'(order[g]), 8'h60 + 8'(order[g]), 8'hC0 + 8'(order[g]));
      exp_rsp(order[g], 1'b0, 8'h00);
    end
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 8'h10 + 8'(i), 8'h60 + 8'(i), 8'hC0 + 8'(i));
    for (int g = 0; g < 5; g++) wait_ready(order[g]);
    tick();
    req_valid = '0;
    wait_idle();

    repeat (5) tick();
    chk("grant_queue_empty", 32'(gq.size()), 0);
    chk("rsp_queue_empty", 32'(rq.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
